store_buffer: RTL and testbench

Write buffer between the processor memory stage and Data_Memory, a word-addressed memory that writes on negedge and reads combinationally. Stores are queued in a small FIFO and drained to memory one per cycle when the port is idle, so stores never stall the pipeline unless the FIFO is full. Loads take the memory port first and get store-to-load forwarding from the youngest matching buffered store. Sits between the execute/memory pipeline register and Data_Memory; owns Data_Memory's memWrite, memRead, address and writeData.

---
 rtl/store_buffer_pkg.sv | 16 +
 rtl/sb_fwd_match.sv | 38 +++
 rtl/store_buffer.sv | 132 +++++++++++++
 tb/tb_store_buffer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants and the buffered-store entry layout for the store buffer.
package store_buffer_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    // One queued store: word address only, since byte offsets are ignored.
    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:2] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: finds the youngest valid entry whose word
// address matches the load and returns its data.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = SB_PTR_W
) (
    input  sb_entry_t              entries [DEPTH],
    input  logic [PTR_W-1:0]       head,
    input  logic [PTR_W-1:0]       tail,
    input  logic [SB_ADDR_W-1:2]   ld_word,
    output logic                   hit,
    output logic [SB_DATA_W-1:0]   hit_data
);

    logic [PTR_W-1:0] idx;

    // The head pointer is not needed for the scan itself: valid bits mark exactly
    // the occupied slots, so walking DEPTH slots back from tail-1 ends at head.
    logic unused_head;
    assign unused_head = ^head;

    // Age-ordered scan from the youngest entry (tail-1) back toward head; the first hit wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PTR_W'(1) - PTR_W'(i);
            if (!hit && entries[idx].valid && (entries[idx].addr == ld_word)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and Data_Memory. Stores queue in a
// circular FIFO and drain one per idle port cycle; loads own the port first and
// see the youngest matching buffered store via forwarding.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   ld_ready,
    output logic [DATA_W-1:0]      ld_data,
    output logic                   ld_fwd,
    input  logic                   drain_req,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   mem_memWrite,
    output logic                   mem_memRead,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_writeData,
    input  logic [DATA_W-1:0]      mem_readData
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          entries_q [DEPTH];
    sb_entry_t          entries_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               full;
    logic               load_slot;
    logic               drain_slot;
    logic               push;
    logic               pop;
    logic               fwd_hit;
    logic [DATA_W-1:0]  fwd_data;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign st_ready  = !full && !drain_req;
    assign push      = st_valid && st_ready;

    // When full the load slot is withheld so the drain always makes progress.
    assign load_slot  = ld_valid && !full;
    assign drain_slot = !load_slot && !empty;
    assign pop        = drain_slot;
    assign ld_ready   = load_slot;

    // Memory port mux: load, then drain of the head entry, otherwise idle with zeros.
    always_comb begin
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        mem_address   = '0;
        mem_writeData = '0;
        if (load_slot) begin
            mem_memRead = 1'b1;
            mem_address = ld_addr;
        end else if (drain_slot) begin
            mem_memWrite  = 1'b1;
            mem_address   = {entries_q[head_q].addr, 2'b00};
            mem_writeData = entries_q[head_q].data;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd (
        .entries  (entries_q),
        .head     (head_q),
        .tail     (tail_q),
        .ld_word  (ld_addr[ADDR_W-1:2]),
        .hit      (fwd_hit),
        .hit_data (fwd_data)
    );

    assign ld_data = fwd_hit ? fwd_data : mem_readData;
    assign ld_fwd  = ld_valid && fwd_hit;

    // Next-state for the FIFO: retire the head on a drain, append at tail on an accepted store.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + PTR_W'(1);
        end
        if (push) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].addr  = st_addr[ADDR_W-1:2];
            entries_d[tail_q].data  = st_data;
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every buffered store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a negedge-write, combinational-read
// Data_Memory model attached to the memory port.
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_fwd;
    logic        drain_req;
    logic        empty;
    logic [2:0]  count;
    logic        mem_memWrite;
    logic        mem_memRead;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;

    logic [31:0] mem_model [64];

    int compared;
    int mismatched;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic        dr;
        logic        chk_ld;
        logic        e_st_ready;
        logic        e_ld_ready;
        logic [31:0] e_ld_data;
        logic        e_ld_fwd;
        logic        e_empty;
        logic [2:0]  e_count;
        logic        e_wr;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs [20];

    store_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .st_valid      (st_valid),
        .st_addr       (st_addr),
        .st_data       (st_data),
        .st_ready      (st_ready),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .ld_fwd        (ld_fwd),
        .drain_req     (drain_req),
        .empty         (empty),
        .count         (count),
        .mem_memWrite  (mem_memWrite),
        .mem_memRead   (mem_memRead),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Memory model: writes on the falling edge, reads combinationally.
    always @(negedge clk) begin
        if (mem_memWrite) mem_model[mem_address[7:2]] <= mem_writeData;
    end
    assign mem_readData = mem_model[mem_address[7:2]];

    function automatic vec_t mkv(
        input logic sv, input logic [31:0] sa, input logic [31:0] sd,
        input logic lv, input logic [31:0] la, input logic dr, input logic chk_ld,
        input logic e_st_ready, input logic e_ld_ready, input logic [31:0] e_ld_data,
        input logic e_ld_fwd, input logic e_empty, input logic [2:0] e_count,
        input logic e_wr, input logic e_rd, input logic [31:0] e_addr, input logic [31:0] e_wdata);
        vec_t v;
        v.sv = sv; v.sa = sa; v.sd = sd; v.lv = lv; v.la = la; v.dr = dr; v.chk_ld = chk_ld;
        v.e_st_ready = e_st_ready; v.e_ld_ready = e_ld_ready; v.e_ld_data = e_ld_data;
        v.e_ld_fwd = e_ld_fwd; v.e_empty = e_empty; v.e_count = e_count;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_addr = e_addr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        st_valid  = v.sv;
        st_addr   = v.sa;
        st_data   = v.sd;
        ld_valid  = v.lv;
        ld_addr   = v.la;
        drain_req = v.dr;
    endtask

    task automatic checkOutput(input int n, input vec_t v);
        checkVal($sformatf("v%0d_st_ready", n), 32'(st_ready), 32'(v.e_st_ready));
        checkVal($sformatf("v%0d_ld_ready", n), 32'(ld_ready), 32'(v.e_ld_ready));
        checkVal($sformatf("v%0d_ld_fwd", n), 32'(ld_fwd), 32'(v.e_ld_fwd));
        checkVal($sformatf("v%0d_empty", n), 32'(empty), 32'(v.e_empty));
        checkVal($sformatf("v%0d_count", n), 32'(count), 32'(v.e_count));
        checkVal($sformatf("v%0d_memWrite", n), 32'(mem_memWrite), 32'(v.e_wr));
        checkVal($sformatf("v%0d_memRead", n), 32'(mem_memRead), 32'(v.e_rd));
        checkVal($sformatf("v%0d_address", n), mem_address, v.e_addr);
        checkVal($sformatf("v%0d_writeData", n), mem_writeData, v.e_wdata);
        if (v.chk_ld) checkVal($sformatf("v%0d_ld_data", n), ld_data, v.e_ld_data);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        drain_req = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'hD000_0000 + i;
        clearInputs();
        rst_n = 1'b0;

        //         sv sa         sd            lv la         dr chk srdy lrdy ld_data       fwd emp cnt wr rd addr       wdata
        vecs[0]  = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h00, 32'h0);
        vecs[1]  = mkv(1, 32'h10, 32'hAAAA0001, 0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h00, 32'h0);
        vecs[2]  = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h10, 32'hAAAA0001);
        vecs[3]  = mkv(0, 32'h00, 32'h0,        1, 32'h10, 0, 1,  1, 1, 32'hAAAA0001,  0, 1, 0, 0, 1, 32'h10, 32'h0);
        vecs[4]  = mkv(1, 32'h20, 32'h1,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h00, 32'h0);
        vecs[5]  = mkv(1, 32'h20, 32'h2,        1, 32'h23, 0, 1,  1, 1, 32'h1,         1, 0, 1, 0, 1, 32'h23, 32'h0);
        vecs[6]  = mkv(0, 32'h00, 32'h0,        1, 32'h20, 0, 1,  1, 1, 32'h2,         1, 0, 2, 0, 1, 32'h20, 32'h0);
        vecs[7]  = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 2, 1, 0, 32'h20, 32'h1);
        vecs[8]  = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h20, 32'h2);
        vecs[9]  = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 1, 0, 0, 0, 32'h00, 32'h0);
        vecs[10] = mkv(1, 32'h30, 32'h11,       1, 32'h40, 0, 1,  1, 1, 32'hD0000010,  0, 1, 0, 0, 1, 32'h40, 32'h0);
        vecs[11] = mkv(1, 32'h34, 32'h12,       1, 32'h40, 0, 1,  1, 1, 32'hD0000010,  0, 0, 1, 0, 1, 32'h40, 32'h0);
        vecs[12] = mkv(1, 32'h38, 32'h13,       1, 32'h40, 0, 1,  1, 1, 32'hD0000010,  0, 0, 2, 0, 1, 32'h40, 32'h0);
        vecs[13] = mkv(1, 32'h3C, 32'h14,       1, 32'h40, 0, 1,  1, 1, 32'hD0000010,  0, 0, 3, 0, 1, 32'h40, 32'h0);
        vecs[14] = mkv(0, 32'h00, 32'h0,        1, 32'h40, 0, 0,  0, 0, 32'h0,         0, 0, 4, 1, 0, 32'h30, 32'h11);
        vecs[15] = mkv(0, 32'h00, 32'h0,        1, 32'h40, 0, 1,  1, 1, 32'hD0000010,  0, 0, 3, 0, 1, 32'h40, 32'h0);
        vecs[16] = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 3, 1, 0, 32'h34, 32'h12);
        vecs[17] = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 2, 1, 0, 32'h38, 32'h13);
        vecs[18] = mkv(0, 32'h00, 32'h0,        0, 32'h00, 0, 0,  1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h3C, 32'h14);
        vecs[19] = mkv(0, 32'h00, 32'h0,        1, 32'h3C, 0, 1,  1, 1, 32'h14,        0, 1, 0, 0, 1, 32'h3C, 32'h0);

        // Reset state
        #3;
        checkVal("rst_count", 32'(count), 32'h0);
        checkVal("rst_empty", 32'(empty), 32'h1);
        checkVal("rst_st_ready", 32'(st_ready), 32'h1);
        checkVal("rst_memWrite", 32'(mem_memWrite), 32'h0);
        checkVal("rst_memRead", 32'(mem_memRead), 32'h0);
        checkVal("rst_address", mem_address, 32'h0);
        checkVal("rst_writeData", mem_writeData, 32'h0);
        checkVal("rst_ld_fwd", 32'(ld_fwd), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Table-driven cycles: single store drain, forwarding, full FIFO arbitration
        for (int n = 0; n < 20; n++) begin
            applyStimulus(vecs[n]);
            #6;
            checkOutput(n, vecs[n]);
            nextCycle();
        end
        clearInputs();

        // Pointer wrap: ten back-to-back stores, each drained the following cycle
        for (int k = 0; k < 10; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'(4 * k);
            st_data  = 32'h100 + 32'(k);
            #6;
            checkVal($sformatf("wrap%0d_count", k), 32'(count), (k == 0) ? 32'h0 : 32'h1);
            if (k > 0) begin
                checkVal($sformatf("wrap%0d_memWrite", k), 32'(mem_memWrite), 32'h1);
                checkVal($sformatf("wrap%0d_address", k), mem_address, 32'(4 * (k - 1)));
                checkVal($sformatf("wrap%0d_writeData", k), mem_writeData, 32'h100 + 32'(k - 1));
            end
            nextCycle();
        end
        clearInputs();
        #6;
        checkVal("wrap_last_address", mem_address, 32'h24);
        checkVal("wrap_last_writeData", mem_writeData, 32'h109);
        nextCycle();
        #6;
        checkVal("wrap_end_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 10; i++) begin
            checkVal($sformatf("wrap_mem%0d", i), mem_model[i], 32'h100 + 32'(i));
        end
        nextCycle();

        // drain_req: queue three stores behind loads, then drain with stores blocked
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h50 + 32'(4 * k);
            st_data  = 32'h21 + 32'(k);
            ld_valid = 1'b1;
            ld_addr  = 32'h80;
            nextCycle();
        end
        ld_valid  = 1'b0;
        st_valid  = 1'b1;
        st_addr   = 32'h5C;
        st_data   = 32'hBAD;
        drain_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #6;
            checkVal($sformatf("drq%0d_st_ready", k), 32'(st_ready), 32'h0);
            checkVal($sformatf("drq%0d_count", k), 32'(count), 32'(3 - k));
            checkVal($sformatf("drq%0d_address", k), mem_address, 32'h50 + 32'(4 * k));
            nextCycle();
        end
        #6;
        checkVal("drq_empty", 32'(empty), 32'h1);
        checkVal("drq_hold_st_ready", 32'(st_ready), 32'h0);
        nextCycle();
        clearInputs();
        #1;
        checkVal("drq_release_st_ready", 32'(st_ready), 32'h1);
        nextCycle();
        checkVal("drq_blocked_store", mem_model[23], 32'hD0000017);
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("drq_mem%0d", i), mem_model[20 + i], 32'h21 + 32'(i));
        end

        // Asynchronous reset discards three queued stores
        for (int k = 0; k < 3; k++) begin
            st_valid = 1'b1;
            st_addr  = 32'h60 + 32'(4 * k);
            st_data  = 32'h31 + 32'(k);
            ld_valid = 1'b1;
            ld_addr  = 32'h80;
            nextCycle();
        end
        checkVal("prerst_count", 32'(count), 32'h3);
        clearInputs();
        rst_n = 1'b0;
        #1;
        checkVal("arst_count", 32'(count), 32'h0);
        checkVal("arst_empty", 32'(empty), 32'h1);
        checkVal("arst_memWrite", 32'(mem_memWrite), 32'h0);
        checkVal("arst_st_ready", 32'(st_ready), 32'h1);
        nextCycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #6;
            checkVal($sformatf("postrst%0d_memWrite", k), 32'(mem_memWrite), 32'h0);
            nextCycle();
        end
        for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("postrst_mem%0d", i), mem_model[24 + i], 32'hD0000018 + 32'(i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
